// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin arbiter for a shared tristate line: one-hot grant,
// decoder select, bus enable, turnaround gaps between owners and a hold timeout.
`timescale 1ns/1ps

module bus_arbiter_rr #(
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       bus_en,
    output logic       preempt
);

    localparam int unsigned NUM_MASTERS = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned HOLD_W      = 8;
    localparam int unsigned TCNT_W      = 4;

    localparam logic [HOLD_W-1:0] HOLD_LIMIT   = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT     = '1;
    localparam logic [TCNT_W-1:0] TCNT_INIT    = TCNT_W'(TURNAROUND - 1);
    localparam bit                HOLD_BOUNDED = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [HOLD_W-1:0]   hold;
    logic [TCNT_W-1:0]   tcnt;

    logic                win_valid;
    logic [IDX_W-1:0]    win_idx;
    logic                owner_req;
    logic                hold_expired;
    logic                release_now;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUM_MASTERS'(1) << idx;
    endfunction

    // Rotating-priority scan; descending loop lets the closest requester to ptr win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req[ptr + IDX_W'(k)]) begin
                win_valid = 1'b1;
                win_idx   = ptr + IDX_W'(k);
            end
        end
    end

    assign owner_req    = req[sel];
    assign hold_expired = HOLD_BOUNDED && (hold == HOLD_LIMIT);
    assign release_now  = !owner_req || hold_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            hold    <= '0;
            tcnt    <= '0;
            gnt     <= '0;
            sel     <= '0;
            bus_en  <= 1'b0;
            preempt <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        gnt    <= onehot(win_idx);
                        sel    <= win_idx;
                        bus_en <= 1'b1;
                        hold   <= HOLD_W'(1);
                        state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        // A still-requesting owner can only be leaving on timeout.
                        gnt     <= '0;
                        bus_en  <= 1'b0;
                        ptr     <= sel + IDX_W'(1);
                        tcnt    <= TCNT_INIT;
                        preempt <= owner_req;
                        state   <= S_TURN;
                    end else if (hold != HOLD_SAT) begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                S_TURN: begin
                    if (tcnt != '0) begin
                        tcnt <= tcnt - TCNT_W'(1);
                    end else if (win_valid) begin
                        gnt    <= onehot(win_idx);
                        sel    <= win_idx;
                        bus_en <= 1'b1;
                        hold   <= HOLD_W'(1);
                        state  <= S_GRANT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Single-driver guarantees on the shared line.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_sel:    assert property (@(posedge clk) disable iff (rst)
                                   (gnt != '0) |-> (gnt == onehot(sel)));
    a_bus_en:     assert property (@(posedge clk) disable iff (rst) bus_en == (|gnt));
    a_turn_idle:  assert property (@(posedge clk) disable iff (rst)
                                   (state == S_TURN) |-> (gnt == '0));

endmodule
